// File: rtl/ehgu_modsat_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : ehgu_modsat_counter_if
// Description : Config handshake and counter bus for ehgu_modsat_counter.
//               The count_gray signal exists only when
//               EHGU_MODSAT_COUNTER_GRAY_OUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ehgu_modsat_counter_if #(
   parameter int WIDTH      = 8,
   parameter int STEP_WIDTH = 4
);
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic                  cfg_mode;
   logic [WIDTH:0]        cfg_modulo;
   logic [WIDTH-1:0]      cfg_min;
   logic [WIDTH-1:0]      cfg_max;
   logic                  cfg_err;
   logic                  en;
   logic                  dir_up;
   logic [STEP_WIDTH-1:0] step;
   logic                  load;
   logic [WIDTH-1:0]      load_val;
   logic [WIDTH-1:0]      count;
   logic                  wrapped;
   logic                  saturated;
   logic                  clipped;
   logic                  step_err;
   logic                  busy;
`ifdef EHGU_MODSAT_COUNTER_GRAY_OUT_EN
   logic [WIDTH-1:0]      count_gray;
`endif

   modport slave (
      input  cfg_valid, cfg_mode, cfg_modulo, cfg_min, cfg_max,
      input  en, dir_up, step, load, load_val,
      output cfg_ready, cfg_err, count, wrapped, saturated, clipped,
      output step_err, busy
`ifdef EHGU_MODSAT_COUNTER_GRAY_OUT_EN
      , output count_gray
`endif
   );

   modport master (
      output cfg_valid, cfg_mode, cfg_modulo, cfg_min, cfg_max,
      output en, dir_up, step, load, load_val,
      input  cfg_ready, cfg_err, count, wrapped, saturated, clipped,
      input  step_err, busy
`ifdef EHGU_MODSAT_COUNTER_GRAY_OUT_EN
      , input count_gray
`endif
   );
endinterface
`default_nettype wire

// File: rtl/ehgu_modsat_counter.sv
`default_nettype none
// ============================================================================
// Module      : ehgu_modsat_counter
// Description : Run-time configurable modulo/saturate counter with step,
//               direction and load. Config changes are accepted over a
//               valid/ready handshake and followed by a one-cycle realign
//               that pulls the live count into the new range.
//               Optional macro EHGU_MODSAT_COUNTER_GRAY_OUT_EN adds a
//               registered Gray-coded copy of the count.
// Revision    : 1.0 - initial release
// ============================================================================
module ehgu_modsat_counter #(
   parameter int WIDTH      = 8,
   parameter int STEP_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ehgu_modsat_counter_if.slave   bus
);
   localparam logic [1:0]     c_ST_IDLE    = 2'd0;
   localparam logic [1:0]     c_ST_REALIGN = 2'd1;
   localparam logic [1:0]     c_ST_RUN     = 2'd2;
   localparam logic [WIDTH:0] c_MOD_FULL   = {1'b1, {WIDTH{1'b0}}};

   logic [1:0]       r_state;
   logic             r_mode;
   logic [WIDTH:0]   r_modulo;
   logic [WIDTH-1:0] r_min;
   logic [WIDTH-1:0] r_max;
   logic [WIDTH-1:0] r_count;
   logic             r_wrapped;
   logic             r_saturated;
   logic             r_clipped;
   logic             r_step_err;
   logic             r_cfg_err;

   logic             w_cfg_ready;
   logic             w_cfg_fire;
   logic             w_cfg_legal;
   logic             w_cfg_take;
   logic [WIDTH:0]   w_count_ext;
   logic [WIDTH:0]   w_step_ext;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_floor;
   logic [WIDTH-1:0] w_wrap_up;
   logic [WIDTH-1:0] w_wrap_dn;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_mod_last;
   logic [3:0]       w_unused_msbs;
   logic [WIDTH-1:0] w_clip_in;
   logic [WIDTH-1:0] w_clip_out;

   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_wrapped_nxt;
   logic             w_saturated_nxt;
   logic             w_clipped_nxt;
   logic             w_step_err_nxt;

   // Handshake: config is refused only while realigning.
   assign w_cfg_ready = (r_state != c_ST_REALIGN);
   assign w_cfg_fire  = bus.cfg_valid && w_cfg_ready;
   assign w_cfg_legal = (bus.cfg_modulo != '0) && (bus.cfg_modulo <= c_MOD_FULL) &&
                        (bus.cfg_min <= bus.cfg_max);
   assign w_cfg_take  = w_cfg_fire && w_cfg_legal;

   // Arithmetic is done one bit wider so carries and borrows are visible.
   assign w_count_ext = {1'b0, r_count};
   assign w_step_ext  = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, bus.step};
   assign w_sum       = w_count_ext + w_step_ext;
   assign w_floor     = {1'b0, r_min} + w_step_ext;
   assign {w_unused_msbs[0], w_wrap_up}  = w_sum - r_modulo;
   assign {w_unused_msbs[1], w_wrap_dn}  = w_count_ext + r_modulo - w_step_ext;
   assign {w_unused_msbs[2], w_diff}     = w_count_ext - w_step_ext;
   assign {w_unused_msbs[3], w_mod_last} = r_modulo - 1'b1;

   // A single clip unit serves realign (current count) and load (load_val).
   assign w_clip_in = (r_state == c_ST_REALIGN) ? r_count : bus.load_val;

   // Force a value into the active range of the current mode.
   always_comb begin
      w_clip_out = w_clip_in;
      if (!r_mode) begin
         if ({1'b0, w_clip_in} >= r_modulo) w_clip_out = w_mod_last;
      end else if (w_clip_in < r_min) begin
         w_clip_out = r_min;
      end else if (w_clip_in > r_max) begin
         w_clip_out = r_max;
      end
   end

   // Next state, next count and the flag pulses that accompany it.
   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_wrapped_nxt   = 1'b0;
      w_saturated_nxt = 1'b0;
      w_clipped_nxt   = 1'b0;
      w_step_err_nxt  = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (w_cfg_take) w_state_nxt = c_ST_REALIGN;
         end
         c_ST_REALIGN: begin
            w_count_nxt   = w_clip_out;
            w_clipped_nxt = (w_clip_out != r_count);
            w_state_nxt   = c_ST_RUN;
         end
         c_ST_RUN: begin
            if (w_cfg_take) begin
               w_state_nxt = c_ST_REALIGN;
            end else if (bus.load) begin
               w_count_nxt   = w_clip_out;
               w_clipped_nxt = (w_clip_out != bus.load_val);
            end else if (bus.en) begin
               if (!r_mode) begin
                  if (w_step_ext >= r_modulo) begin
                     w_step_err_nxt = 1'b1;
                  end else if (bus.dir_up) begin
                     if (w_sum >= r_modulo) begin
                        w_count_nxt   = w_wrap_up;
                        w_wrapped_nxt = 1'b1;
                     end else begin
                        w_count_nxt = w_sum[WIDTH-1:0];
                     end
                  end else if (w_count_ext < w_step_ext) begin
                     w_count_nxt   = w_wrap_dn;
                     w_wrapped_nxt = 1'b1;
                  end else begin
                     w_count_nxt = w_diff;
                  end
               end else if (bus.dir_up) begin
                  if (w_sum > {1'b0, r_max}) begin
                     w_count_nxt     = r_max;
                     w_saturated_nxt = 1'b1;
                  end else begin
                     w_count_nxt = w_sum[WIDTH-1:0];
                  end
               end else if (w_count_ext < w_floor) begin
                  w_count_nxt     = r_min;
                  w_saturated_nxt = 1'b1;
               end else begin
                  w_count_nxt = w_diff;
               end
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // State, config, count and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_ST_IDLE;
         r_mode      <= 1'b0;
         r_modulo    <= c_MOD_FULL;
         r_min       <= '0;
         r_max       <= '1;
         r_count     <= '0;
         r_wrapped   <= 1'b0;
         r_saturated <= 1'b0;
         r_clipped   <= 1'b0;
         r_step_err  <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_wrapped   <= w_wrapped_nxt;
         r_saturated <= w_saturated_nxt;
         r_clipped   <= w_clipped_nxt;
         r_step_err  <= w_step_err_nxt;
         r_cfg_err   <= w_cfg_fire && !w_cfg_legal;
         if (w_cfg_take) begin
            r_mode   <= bus.cfg_mode;
            r_modulo <= bus.cfg_modulo;
            r_min    <= bus.cfg_min;
            r_max    <= bus.cfg_max;
         end
      end
   end

`ifdef EHGU_MODSAT_COUNTER_GRAY_OUT_EN
   logic [WIDTH-1:0] r_count_gray;

   // Gray copy is built from the next count so it lands with count itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_count_gray <= '0;
      else        r_count_gray <= w_count_nxt ^ (w_count_nxt >> 1);
   end

   assign bus.count_gray = r_count_gray;
`endif

   assign bus.cfg_ready = w_cfg_ready;
   assign bus.cfg_err   = r_cfg_err;
   assign bus.count     = r_count;
   assign bus.wrapped   = r_wrapped;
   assign bus.saturated = r_saturated;
   assign bus.clipped   = r_clipped;
   assign bus.step_err  = r_step_err;
   assign bus.busy      = (r_state != c_ST_RUN);
endmodule
`default_nettype wire

// File: doc/ehgu_modsat_counter.md
Name: ehgu_modsat_counter

Overview:
- Registered, run-time configurable counter for the ehgu datapath. Supports modulo (wrap) and saturate (clip) modes, programmable step, up/down direction and load.
- Config changes go through a valid/ready handshake; a one-cycle realign state pulls the live count into the new range.
- Sits beside ehgu datapath logic as the stateful successor to the combinational increment/decrement/clip helpers.

Parameters:
- WIDTH, 8, count width in bits (2..32).
- STEP_WIDTH, 4, step input width; must be <= WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; a transfer occurs when cfg_valid && cfg_ready.
- cfg_mode  in  1  0 = modulo, 1 = saturate.
- cfg_modulo  in  WIDTH+1  modulo value, legal range 1..2**WIDTH.
- cfg_min  in  WIDTH  saturate floor.
- cfg_max  in  WIDTH  saturate ceiling.
- cfg_err  out  1  one-cycle pulse: illegal config rejected.
- en  in  1  advance count by step.
- dir_up  in  1  1 = up, 0 = down.
- step  in  STEP_WIDTH  step amount.
- load  in  1  load request; has priority over en.
- load_val  in  WIDTH  load value.
- count  out  WIDTH  registered count.
- wrapped  out  1  pulse: modulo wrap occurred this update.
- saturated  out  1  pulse: saturate clamp occurred this update.
- clipped  out  1  pulse: load or realign value was forced into range.
- step_err  out  1  pulse: in modulo mode, step >= modulo; count held.
- busy  out  1  high in IDLE and REALIGN.

Behaviour:
- Reset values:
  - count = 0; all pulses = 0; cfg_ready = 1; busy = 1; state = IDLE.
  - Config registers: mode = modulo, modulo = 2**WIDTH, min = 0, max = all ones.
- FSM states and transitions:
  - IDLE: en and load are ignored. An accepted legal config moves to REALIGN.
  - REALIGN: exactly one cycle. cfg_ready = 0. en and load are ignored. Then RUN.
  - RUN: cfg_ready = 1. An accepted legal config moves to REALIGN, and any en/load in that same cycle is dropped.
- Config legality:
  - Illegal when cfg_modulo == 0, or cfg_modulo > 2**WIDTH, or cfg_min > cfg_max. The check applies regardless of mode.
  - Illegal config: the handshake still completes; cfg_err pulses the next cycle; config and state are unchanged.
- Realign clip:
  - Modulo mode: if count >= modulo, count becomes modulo-1.
  - Saturate mode: count is clamped to [min, max].
  - clipped pulses if the value changed.
- RUN update priority: load, then en, then hold. All results are registered with 1-cycle latency; pulses are high for exactly the cycle in which the new count is visible.
- Load: load_val is clipped per the active mode exactly as in realign; clipped pulses if it changed.
- Modulo up: sum = count + step computed in WIDTH+1 bits. If sum >= modulo, next = sum - modulo and wrapped = 1; otherwise next = sum.
- Modulo down: if count < step, next = count + modulo - step and wrapped = 1; otherwise next = count - step.
- Modulo step check: step >= modulo gives step_err = 1 and count held; this check precedes the arithmetic.
- Saturate up: if count + step > max, next = max and saturated = 1.
- Saturate down: if count < min + step (computed in WIDTH+1 bits), next = min and saturated = 1. An exact landing on min or max is not saturation.
- step = 0 with en: count held; no pulses.
- Reset asserted mid-operation (including during REALIGN): immediate return to reset values; the pending config is lost.

Optional Feature:
- Macro: EHGU_MODSAT_COUNTER_GRAY_OUT_EN.
- Defined: adds output count_gray (WIDTH) = count ^ (count >> 1), registered in the same cycle as count (no extra latency); reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then en with no config -> count stays 0, busy = 1; config mode=0, modulo=10 -> cfg_ready low 1 cycle, busy falls after REALIGN.
- Modulo=10, count=8, step=3, up -> count=1, wrapped=1; then down, step=4 -> count=7, wrapped=1; step=10 -> step_err=1, count held at 7.
- Saturate, min=5, max=200, count=198, step=2, up -> count=200, saturated=0; next step=1 -> count=200, saturated=1; load 2 -> count=5, clipped=1.
- RUN at count=250 (mode=0, modulo=256); config mode=0, modulo=100 in the same cycle as en -> en dropped, REALIGN sets count=99, clipped=1; config min=9, max=3 -> cfg_err=1, config unchanged.
- load and en in the same cycle, load_val=42, mode=0, modulo=256 -> count=42, no wrap; rst_n low during REALIGN -> count=0, state IDLE, cfg_ready=1.
- With EHGU_MODSAT_COUNTER_GRAY_OUT_EN, count 7 -> 8 -> count_gray 0x04 -> 0x0C, same cycle as count.
